// File: rtl/kbd_move_decoder.sv
`default_nettype none
// ============================================================================
// Module      : kbd_move_decoder
// Description : PS/2 set-2 scan-byte parser for the character mover.
//               Tracks E0/F0 prefixes, keeps held flags for left/right/space,
//               resolves left/right with "last pressed wins" and emits a
//               one-cycle shoot pulse on a fresh space make.
// Ports       : clk        - system clock
//               resetN     - synchronous active-low reset
//               scanByte   - received scan byte (valid when byteValid=1)
//               byteValid  - one-cycle strobe per received byte
//               leftPress  - level, left movement requested
//               rightPress - level, right movement requested
//               shootPulse - one-cycle pulse on a fresh space make
//               leftHeld   - raw held state of the left key
//               rightHeld  - raw held state of the right key
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_move_decoder #(
    parameter logic [7:0] LEFT_CODE      = 8'h6B,
    parameter logic [7:0] RIGHT_CODE     = 8'h74,
    parameter logic [7:0] SHOOT_CODE     = 8'h29,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] scanByte,
    input  logic       byteValid,
    output logic       leftPress,
    output logic       rightPress,
    output logic       shootPulse,
    output logic       leftHeld,
    output logic       rightHeld
);

    localparam int              CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       c_EXT_CODE = 8'hE0;
    localparam logic [7:0]       c_BRK_CODE = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    dir_t             r_dir;
    dir_t             w_dir_nxt;
    logic             r_left_held;
    logic             r_right_held;
    logic             r_space_held;
    logic             w_left_nxt;
    logic             w_right_nxt;
    logic             w_space_nxt;
    logic             r_left_press;
    logic             r_right_press;
    logic             r_shoot;
    logic             w_timeout;
    logic             w_make_left;
    logic             w_brk_left;
    logic             w_make_right;
    logic             w_brk_right;
    logic             w_make_space;
    logic             w_brk_space;

    // Parser next-state and key-event decode
    always_comb begin
        w_state_nxt  = r_state;
        w_make_left  = 1'b0;
        w_brk_left   = 1'b0;
        w_make_right = 1'b0;
        w_brk_right  = 1'b0;
        w_make_space = 1'b0;
        w_brk_space  = 1'b0;
        w_timeout    = (r_state != ST_IDLE) && (r_cnt == c_TMO_LAST);

        // A strobe on the timeout cycle wins: the byte is decoded normally.
        if (byteValid) begin
            case (r_state)
                ST_IDLE: begin
                    if (scanByte == c_EXT_CODE)      w_state_nxt  = ST_EXT;
                    else if (scanByte == c_BRK_CODE) w_state_nxt  = ST_BRK;
                    else if (scanByte == SHOOT_CODE) w_make_space = 1'b1;
                end
                ST_EXT: begin
                    w_state_nxt = ST_IDLE;
                    if (scanByte == c_BRK_CODE)      w_state_nxt  = ST_EXT_BRK;
                    else if (scanByte == LEFT_CODE)  w_make_left  = 1'b1;
                    else if (scanByte == RIGHT_CODE) w_make_right = 1'b1;
                end
                ST_BRK: begin
                    w_state_nxt = ST_IDLE;
                    if (scanByte == SHOOT_CODE) w_brk_space = 1'b1;
                end
                ST_EXT_BRK: begin
                    w_state_nxt = ST_IDLE;
                    if (scanByte == LEFT_CODE)       w_brk_left  = 1'b1;
                    else if (scanByte == RIGHT_CODE) w_brk_right = 1'b1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Held flags and direction arbitration
    always_comb begin
        w_left_nxt  = r_left_held;
        w_right_nxt = r_right_held;
        w_space_nxt = r_space_held;
        w_dir_nxt   = r_dir;

        if (w_make_left)  w_left_nxt  = 1'b1;
        if (w_brk_left)   w_left_nxt  = 1'b0;
        if (w_make_right) w_right_nxt = 1'b1;
        if (w_brk_right)  w_right_nxt = 1'b0;
        if (w_make_space) w_space_nxt = 1'b1;
        if (w_brk_space)  w_space_nxt = 1'b0;

        // Only fresh makes steal direction; typematic repeats are ignored.
        if (w_make_left && !r_left_held) begin
            w_dir_nxt = DIR_LEFT;
        end else if (w_make_right && !r_right_held) begin
            w_dir_nxt = DIR_RIGHT;
        end else if (w_brk_left && (r_dir == DIR_LEFT)) begin
            w_dir_nxt = r_right_held ? DIR_RIGHT : DIR_NONE;
        end else if (w_brk_right && (r_dir == DIR_RIGHT)) begin
            w_dir_nxt = r_left_held ? DIR_LEFT : DIR_NONE;
        end

        if (!w_left_nxt && !w_right_nxt) w_dir_nxt = DIR_NONE;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_dir         <= DIR_NONE;
            r_left_held   <= 1'b0;
            r_right_held  <= 1'b0;
            r_space_held  <= 1'b0;
            r_left_press  <= 1'b0;
            r_right_press <= 1'b0;
            r_shoot       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (byteValid || (r_state == ST_IDLE) || w_timeout) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_dir         <= w_dir_nxt;
            r_left_held   <= w_left_nxt;
            r_right_held  <= w_right_nxt;
            r_space_held  <= w_space_nxt;
            r_left_press  <= (w_dir_nxt == DIR_LEFT);
            r_right_press <= (w_dir_nxt == DIR_RIGHT);
            r_shoot       <= w_make_space && !r_space_held;
        end
    end

    assign leftPress  = r_left_press;
    assign rightPress = r_right_press;
    assign shootPulse = r_shoot;
    assign leftHeld   = r_left_held;
    assign rightHeld  = r_right_held;

endmodule
`default_nettype wire

// File: tb/tb_kbd_move_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_kbd_move_decoder
// Description : Directed self-checking bench for kbd_move_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_move_decoder;

    localparam int c_TMO = 16;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [7:0] scanByte = 8'h00;
    logic       byteValid = 1'b0;
    logic       leftPress;
    logic       rightPress;
    logic       shootPulse;
    logic       leftHeld;
    logic       rightHeld;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    kbd_move_decoder #(
        .LEFT_CODE      (8'h6B),
        .RIGHT_CODE     (8'h74),
        .SHOOT_CODE     (8'h29),
        .TIMEOUT_CYCLES (c_TMO)
    ) u_dut (
        .clk        (clk),
        .resetN     (resetN),
        .scanByte   (scanByte),
        .byteValid  (byteValid),
        .leftPress  (leftPress),
        .rightPress (rightPress),
        .shootPulse (shootPulse),
        .leftHeld   (leftHeld),
        .rightHeld  (rightHeld)
    );

    always #5 clk = ~clk;

    // Counts high cycles of shootPulse
    always @(negedge clk) begin
        if (shootPulse) pulse_cnt <= pulse_cnt + 1;
    end

    // Drive one byte strobe; returns on the negedge after the strobe edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scanByte  = b;
        byteValid = 1'b1;
        @(negedge clk);
        byteValid = 1'b0;
        scanByte  = 8'h00;
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        checks++;
        if ({leftPress, rightPress, shootPulse, leftHeld, rightHeld} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b exp %b",
                     {leftPress, rightPress, shootPulse, leftHeld, rightHeld}, 5'b00000);
        end
        // Reset in the middle of an E0 prefix must discard it
        send_byte(8'hE0);
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        send_byte(8'h6B);
        checks++;
        if ({leftPress, leftHeld} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_prefix: got %b exp %b", {leftPress, leftHeld}, 2'b00);
        end
        // Reset clears held state and outputs
        send_byte(8'hE0);
        send_byte(8'h6B);
        checks++;
        if ({leftPress, leftHeld} !== 2'b11) begin
            errors++;
            $display("FAIL reset_pre_left: got %b exp %b", {leftPress, leftHeld}, 2'b11);
        end
        resetN = 1'b0;
        @(negedge clk);
        checks++;
        if ({leftPress, rightPress, leftHeld, rightHeld} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_clears_held: got %b exp %b",
                     {leftPress, rightPress, leftHeld, rightHeld}, 4'b0000);
        end
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_basic_move;
        send_byte(8'hE0);
        @(negedge clk);
        scanByte  = 8'h74;
        byteValid = 1'b1;
        // Before the strobe edge nothing has changed yet
        checks++;
        if ({leftPress, rightPress} !== 2'b00) begin
            errors++;
            $display("FAIL move_latency: got %b exp %b", {leftPress, rightPress}, 2'b00);
        end
        @(negedge clk);
        byteValid = 1'b0;
        checks++;
        if ({leftPress, rightPress, rightHeld} !== 3'b011) begin
            errors++;
            $display("FAIL move_right_make: got %b exp %b", {leftPress, rightPress, rightHeld}, 3'b011);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h74);
        checks++;
        if ({leftPress, rightPress, rightHeld} !== 3'b000) begin
            errors++;
            $display("FAIL move_right_break: got %b exp %b", {leftPress, rightPress, rightHeld}, 3'b000);
        end
    endtask

    task automatic test_last_wins;
        send_byte(8'hE0); send_byte(8'h74);
        send_byte(8'hE0); send_byte(8'h6B);
        checks++;
        if ({leftPress, rightPress, leftHeld, rightHeld} !== 4'b1011) begin
            errors++;
            $display("FAIL lpw_left_over_right: got %b exp %b",
                     {leftPress, rightPress, leftHeld, rightHeld}, 4'b1011);
        end
        // Typematic repeat of right must not steal direction
        send_byte(8'hE0); send_byte(8'h74);
        checks++;
        if ({leftPress, rightPress} !== 2'b10) begin
            errors++;
            $display("FAIL lpw_typematic: got %b exp %b", {leftPress, rightPress}, 2'b10);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        checks++;
        if ({leftPress, rightPress, leftHeld, rightHeld} !== 4'b0101) begin
            errors++;
            $display("FAIL lpw_left_break: got %b exp %b",
                     {leftPress, rightPress, leftHeld, rightHeld}, 4'b0101);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        checks++;
        if ({leftPress, rightPress, leftHeld, rightHeld} !== 4'b0000) begin
            errors++;
            $display("FAIL lpw_right_break: got %b exp %b",
                     {leftPress, rightPress, leftHeld, rightHeld}, 4'b0000);
        end
        // Non-last key released: direction stays on the last pressed key
        send_byte(8'hE0); send_byte(8'h6B);
        send_byte(8'hE0); send_byte(8'h74);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        checks++;
        if ({leftPress, rightPress, leftHeld, rightHeld} !== 4'b0101) begin
            errors++;
            $display("FAIL lpw_other_break: got %b exp %b",
                     {leftPress, rightPress, leftHeld, rightHeld}, 4'b0101);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    endtask

    task automatic test_shoot;
        int base;
        base = pulse_cnt;
        send_byte(8'h29);
        checks++;
        if (shootPulse !== 1'b1) begin
            errors++;
            $display("FAIL shoot_first: got %b exp %b", shootPulse, 1'b1);
        end
        for (int i = 0; i < 4; i++) send_byte(8'h29);
        repeat (2) @(negedge clk);
        checks++;
        if (pulse_cnt - base !== 1) begin
            errors++;
            $display("FAIL shoot_typematic: got %0d exp %0d", pulse_cnt - base, 1);
        end
        send_byte(8'hF0); send_byte(8'h29);
        repeat (2) @(negedge clk);
        checks++;
        if (pulse_cnt - base !== 1) begin
            errors++;
            $display("FAIL shoot_break_nopulse: got %0d exp %0d", pulse_cnt - base, 1);
        end
        send_byte(8'h29);
        repeat (2) @(negedge clk);
        checks++;
        if (pulse_cnt - base !== 2) begin
            errors++;
            $display("FAIL shoot_second: got %0d exp %0d", pulse_cnt - base, 2);
        end
        send_byte(8'hF0); send_byte(8'h29);
    endtask

    task automatic test_timeout;
        // Strobe one cycle past the timeout: prefix already dropped
        send_byte(8'hE0);
        repeat (c_TMO - 1) @(negedge clk);
        send_byte(8'h6B);
        checks++;
        if ({leftPress, leftHeld} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_expired: got %b exp %b", {leftPress, leftHeld}, 2'b00);
        end
        // Strobe exactly on the timeout cycle: byte wins
        send_byte(8'hE0);
        repeat (c_TMO - 2) @(negedge clk);
        send_byte(8'h6B);
        checks++;
        if ({leftPress, leftHeld} !== 2'b11) begin
            errors++;
            $display("FAIL timeout_boundary: got %b exp %b", {leftPress, leftHeld}, 2'b11);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        // Strobe at cycle 15 after the prefix
        send_byte(8'hE0);
        repeat (c_TMO - 3) @(negedge clk);
        send_byte(8'h6B);
        checks++;
        if (leftPress !== 1'b1) begin
            errors++;
            $display("FAIL timeout_within: got %b exp %b", leftPress, 1'b1);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        checks++;
        if (leftPress !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cleanup: got %b exp %b", leftPress, 1'b0);
        end
    endtask

    task automatic test_garbage;
        int base;
        send_byte(8'hE0); send_byte(8'h74);
        base = pulse_cnt;
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h29);
        repeat (2) @(negedge clk);
        checks++;
        if ({leftPress, rightPress, rightHeld, pulse_cnt - base} !== {3'b011, 32'd0}) begin
            errors++;
            $display("FAIL garbage_ext_brk_space: got %b/%0d exp 011/0",
                     {leftPress, rightPress, rightHeld}, pulse_cnt - base);
        end
        send_byte(8'hF0); send_byte(8'hF0); send_byte(8'h74);
        checks++;
        if ({leftPress, rightPress, rightHeld} !== 3'b011) begin
            errors++;
            $display("FAIL garbage_f0_f0: got %b exp %b", {leftPress, rightPress, rightHeld}, 3'b011);
        end
        send_byte(8'h6B);
        checks++;
        if ({leftPress, leftHeld} !== 2'b00) begin
            errors++;
            $display("FAIL garbage_keypad4: got %b exp %b", {leftPress, leftHeld}, 2'b00);
        end
        send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h6B);
        checks++;
        if ({leftPress, leftHeld} !== 2'b00) begin
            errors++;
            $display("FAIL garbage_e0_e0: got %b exp %b", {leftPress, leftHeld}, 2'b00);
        end
        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h6B);
        checks++;
        if ({leftPress, rightPress, leftHeld} !== 3'b010) begin
            errors++;
            $display("FAIL garbage_f0_e0: got %b exp %b", {leftPress, rightPress, leftHeld}, 3'b010);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        checks++;
        if ({leftPress, rightPress, rightHeld} !== 3'b000) begin
            errors++;
            $display("FAIL garbage_cleanup: got %b exp %b", {leftPress, rightPress, rightHeld}, 3'b000);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_move();
        test_last_wins();
        test_shoot();
        test_timeout();
        test_garbage();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
